// File: rtl/hazard_scoreboard_if.sv
// Issue/write-back bundle between the pipeline control and the hazard scoreboard.
interface hazard_scoreboard_if;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_reg_write;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;
    logic        underflow_err;
    logic        deadlock_err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_reg_write,
        output wb_reg_write, wb_rd, flush,
        input  stall, busy_mask, stall_count, underflow_err, deadlock_err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_reg_write,
        input  wb_reg_write, wb_rd, flush,
        output stall, busy_mask, stall_count, underflow_err, deadlock_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard with stall generation and deadlock watchdog.
// state   | meaning
// RUN     | no stall was seen at the previous posedge
// STALLED | stall held at the previous posedge; run length is accumulating
module hazard_scoreboard #(
    parameter int MAX_PEND = 3,
    parameter int TIMEOUT  = 64
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam int CW  = $clog2(MAX_PEND + 1);
    localparam int RLW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {RUN, STALLED} state_t;

    logic [CW-1:0]  cnt [32];
    logic [31:0]    wb_hit;
    logic [31:0]    src_busy;
    logic [31:0]    inc;
    logic [31:0]    busy;
    logic           rd_full;
    logic           stall;
    logic           issue_acc;
    logic           underflow_q;

    state_t         state_q, state_d;
    logic [RLW-1:0] run_len_q, run_len_d;
    logic           deadlock_q, deadlock_d;
    logic [15:0]    stall_count_q;

    // A write-back in the same cycle releases one pending write before the hazard check.
    always_comb begin
        wb_hit   = '0;
        src_busy = '0;
        busy     = '0;
        for (int r = 1; r < 32; r++) begin
            wb_hit[r]   = bus.wb_reg_write && (bus.wb_rd == 5'(r));
            src_busy[r] = (cnt[r] > CW'(1)) || ((cnt[r] == CW'(1)) && !wb_hit[r]);
            busy[r]     = (cnt[r] != '0);
        end
    end

    always_comb begin
        rd_full   = bus.issue_reg_write && (bus.issue_rd != 5'd0) &&
                    (cnt[bus.issue_rd] == CW'(MAX_PEND)) && !wb_hit[bus.issue_rd];
        stall     = !reset && bus.issue_valid &&
                    (src_busy[bus.issue_rs1] || src_busy[bus.issue_rs2] || rd_full);
        issue_acc = bus.issue_valid && !stall && bus.issue_reg_write && (bus.issue_rd != 5'd0);
        inc       = '0;
        for (int r = 1; r < 32; r++) begin
            inc[r] = issue_acc && (bus.issue_rd == 5'(r));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc[r] && !wb_hit[r]) begin
                    cnt[r] <= cnt[r] + CW'(1);
                end else if (!inc[r] && wb_hit[r]) begin
                    if (cnt[r] == '0) underflow_q <= 1'b1;
                    else              cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            run_len_q     <= '0;
            deadlock_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q    <= state_d;
            run_len_q  <= run_len_d;
            deadlock_q <= deadlock_d;
            if (stall && (stall_count_q != 16'hFFFF)) stall_count_q <= stall_count_q + 16'd1;
        end
    end

    // Entering STALLED counts the entry cycle itself, so the Nth stalled posedge leaves run_len = N.
    always_comb begin
        state_d    = state_q;
        run_len_d  = run_len_q;
        deadlock_d = deadlock_q;
        case (state_q)
            RUN: begin
                if (stall) begin
                    state_d   = STALLED;
                    run_len_d = RLW'(1);
                end
            end
            STALLED: begin
                if (stall) begin
                    if (run_len_q != RLW'(TIMEOUT)) run_len_d = run_len_q + RLW'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (stall && (run_len_d == RLW'(TIMEOUT))) deadlock_d = 1'b1;
    end

    assign bus.stall         = stall;
    assign bus.busy_mask     = busy;
    assign bus.stall_count   = stall_count_q;
    assign bus.underflow_err = underflow_q;
    assign bus.deadlock_err  = deadlock_q;
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PEND, default 3, meaning the maximum number of outstanding writes tracked per register (2-bit counter).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the number of consecutive stall cycles before a deadlock is flagged.
REQ-003 SHALL have ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- issue_valid  input  1  ID stage presents an instruction.
- issue_rs1, issue_rs2  input  5  source register addresses.
- issue_rd  input  5  destination register address.
- issue_reg_write  input  1  instruction writes issue_rd.
- wb_reg_write  input  1  write-back stage is retiring a register write this cycle.
- wb_rd  input  5  write-back destination.
- flush  input  1  synchronous clear of all pending state.
- stall  output  1  combinational; hold IF/ID this cycle.
- busy_mask  output  32  bit n = 1 when register n has a pending count > 0.
- stall_count  output  16  saturating count of stalled cycles.
- underflow_err  output  1  sticky; write-back without a pending write.
- deadlock_err  output  1  sticky; stall persisted for TIMEOUT cycles.

Function
REQ-004 SHALL keep one 2-bit pending counter cnt[n] per register n = 1..31; register 0 SHALL never be counted, busy or stalled on.
REQ-005 SHALL define wb_hit(r) = wb_reg_write & (wb_rd == r) & (r != 0).
REQ-006 SHALL define src_busy(r) = (cnt[r] > 1) | (cnt[r] == 1 & !wb_hit(r)), so a same-cycle write-back releases its last pending write.
REQ-007 SHALL drive stall = issue_valid & (src_busy(rs1) | src_busy(rs2) | (issue_reg_write & rd != 0 & cnt[rd] == MAX_PEND & !wb_hit(rd))).
REQ-008 SHALL define issue_acc = issue_valid & !stall & issue_reg_write & issue_rd != 0.
REQ-009 SHALL update each counter at posedge:
- issue_acc on r only: +1.
- wb_hit(r) only: -1.
- both on the same r: unchanged.
REQ-010 SHALL, on wb_hit(r) with cnt[r] == 0 and no same-cycle issue_acc on r, leave cnt[r] at 0 and set underflow_err.
REQ-011 SHALL, when flush = 1, clear all counters at that posedge, ignoring issue and write-back that cycle; the sticky errors and stall_count are unaffected.
REQ-012 SHALL derive busy_mask directly from the counters (bit n = cnt[n] != 0; bit 0 always 0).
REQ-013 SHALL implement the FSM RUN / STALLED:
- RUN -> STALLED when stall = 1 at a posedge.
- STALLED -> RUN when stall = 0 at a posedge.
REQ-014 SHALL run a run-length counter that is cleared on each entry to STALLED and increments every stalled cycle; when it reaches TIMEOUT, SHALL set deadlock_err.
REQ-015 SHALL increment stall_count on each posedge with stall = 1 and saturate at 16'hFFFF.
REQ-016 SHALL treat issue_rs1/rs2 as don't-care on cycles with issue_valid = 0, and SHALL never assert stall when issue_valid = 0.

Reset
REQ-017 SHALL, on reset (asynchronous, active-high, at any time including mid-stall), immediately:
- clear all counters (busy_mask = 0);
- set the FSM to RUN and clear the run-length counter;
- clear stall_count, underflow_err and deadlock_err.
REQ-018 SHALL hold stall = 0 while reset is asserted.

Verification
REQ-019 Issue rd=5 write, next cycle issue rs1=5 -> stall=1, busy_mask=32'h20; assert wb_rd=5, wb_reg_write=1 that cycle -> stall=0 same cycle, busy_mask=0 after posedge.
REQ-020 Three writes to rd=7, then a fourth -> fourth stalls (cnt=3); a same-cycle wb_rd=7 -> fourth accepted, cnt stays 3.
REQ-021 wb_reg_write=1, wb_rd=9 with cnt[9]=0 -> underflow_err=1 and cnt[9]=0; issue with rd=0 / rs1=0 -> never busy, never stalls.
REQ-022 Hold a dependent instruction with no write-back for 64 cycles -> deadlock_err=1 on the 64th stalled posedge; stall_count=64.
REQ-023 Pending writes on r3, r4 plus flush=1 alongside a simultaneous issue to r6 -> busy_mask=0 next cycle, r6 not counted.
REQ-024 Assert reset mid-stall -> stall=0, busy_mask=0, stall_count=0 and both errors=0 without waiting for a clock edge.
